tmds_channel_decoder: RTL and testbench



---
 rtl/tmds_channel_decoder.sv | 206 ++++++++++++++++++++
 tb/tb_tmds_channel_decoder.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tmds_channel_decoder.sv
// tmds_channel_decoder
//
// Single-lane TMDS receive decoder. Takes 10-bit words from a 1:10
// deserializer, finds word alignment by hunting for runs of control tokens
// (requesting a bitslip from the deserializer when none are found), then
// decodes each aligned word into DE, the two control bits, or a data byte.
//
// Ports
//   pixel_clock  in   pixel-rate clock, rising edge
//   reset        in   synchronous active-high reset
//   tmds_word    in   [9:0] deserialized word, bit 0 first on the wire
//   bitslip      out  one-cycle request to shift the word boundary by one bit
//   aligned      out  high while locked
//   de           out  data enable (word was not a control token)
//   ctrl         out  [1:0] {c1,c0} from the last control token, held during data
//   data         out  [7:0] decoded byte, valid when de=1
//   err_count    out  [15:0] saturating count of bitslips plus lock losses
//
// Build option
//   TMDS_DEC_ERR_CNT_EN  when defined, err_count counts bitslip pulses and
//                        LOCKED->SEARCH transitions (saturating at 16'hFFFF);
//                        otherwise err_count is tied to zero.
//
// State   | meaning
// --------+--------------------------------------------------------------
// SEARCH  | hunting for CTRL_TOKEN_MIN consecutive control tokens
// SLIP    | bitslip asserted for this single cycle
// WAIT    | deserializer settling after a bitslip; input ignored
// LOCKED  | aligned; words decoded, lock dropped after LINE_TIMEOUT idle

module tmds_channel_decoder #(
  parameter int CTRL_TOKEN_MIN = 8,
  parameter int SEARCH_TIMEOUT = 4096,
  parameter int BITSLIP_WAIT   = 16,
  parameter int LINE_TIMEOUT   = 4096
) (
  input  logic        pixel_clock,
  input  logic        reset,
  input  logic [9:0]  tmds_word,
  output logic        bitslip,
  output logic        aligned,
  output logic        de,
  output logic [1:0]  ctrl,
  output logic [7:0]  data,
  output logic [15:0] err_count
);

  localparam int TOK_W  = $clog2(CTRL_TOKEN_MIN) + 1;
  localparam int SRCH_W = $clog2(SEARCH_TIMEOUT) + 1;
  localparam int WAIT_W = $clog2(BITSLIP_WAIT) + 1;
  localparam int LOSS_W = $clog2(LINE_TIMEOUT) + 1;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    SLIP   = 2'd1,
    WAIT   = 2'd2,
    LOCKED = 2'd3
  } state_t;

  state_t             state;
  logic [9:0]         w1;
  logic [TOK_W-1:0]   tok_cnt;
  logic [SRCH_W-1:0]  srch_cnt;
  logic [WAIT_W-1:0]  wait_cnt;
  logic [LOSS_W-1:0]  loss_cnt;

  logic               is_tok;
  logic [1:0]         tok_ctrl;
  logic [7:0]         d_inv;
  logic [7:0]         dec;
  logic               lock_hit;
  logic               srch_tmo;
  logic               wait_done;
  logic               loss_tmo;

  // Input register stage; everything downstream works from w1.
  always_ff @(posedge pixel_clock) begin
    if (reset) w1 <= '0;
    else       w1 <= tmds_word;
  end

  always_comb begin
    is_tok   = 1'b1;
    tok_ctrl = 2'b00;
    case (w1)
      10'b1101010100: tok_ctrl = 2'b00;
      10'b0010101011: tok_ctrl = 2'b01;
      10'b0101010100: tok_ctrl = 2'b10;
      10'b1010101011: tok_ctrl = 2'b11;
      default:        is_tok   = 1'b0;
    endcase
  end

  // Undo the optional inversion (bit 9), then undo XOR/XNOR chaining (bit 8).
  always_comb begin
    d_inv  = w1[9] ? ~w1[7:0] : w1[7:0];
    dec    = '0;
    dec[0] = d_inv[0];
    for (int i = 1; i < 8; i++) begin
      dec[i] = w1[8] ? (d_inv[i] ^ d_inv[i-1]) : ~(d_inv[i] ^ d_inv[i-1]);
    end
  end

  // Terminal-count compares; lock takes priority over search timeout.
  assign lock_hit  = is_tok && (tok_cnt == TOK_W'(CTRL_TOKEN_MIN - 1));
  assign srch_tmo  = (srch_cnt == SRCH_W'(SEARCH_TIMEOUT - 1));
  assign wait_done = (wait_cnt == WAIT_W'(BITSLIP_WAIT - 1));
  assign loss_tmo  = !is_tok && (loss_cnt == LOSS_W'(LINE_TIMEOUT - 1));

  // Outputs are computed against the state being entered, so de/ctrl/data
  // drop in the same cycle aligned drops and start with the locking token.
  always_ff @(posedge pixel_clock) begin
    if (reset) begin
      state    <= SEARCH;
      tok_cnt  <= '0;
      srch_cnt <= '0;
      wait_cnt <= '0;
      loss_cnt <= '0;
      bitslip  <= 1'b0;
      aligned  <= 1'b0;
      de       <= 1'b0;
      ctrl     <= 2'b00;
      data     <= 8'h00;
    end else begin
      bitslip <= 1'b0;
      case (state)
        SEARCH: begin
          de       <= 1'b0;
          ctrl     <= 2'b00;
          data     <= 8'h00;
          srch_cnt <= srch_cnt + 1'b1;
          tok_cnt  <= is_tok ? tok_cnt + 1'b1 : '0;
          if (lock_hit) begin
            state    <= LOCKED;
            aligned  <= 1'b1;
            ctrl     <= tok_ctrl;
            tok_cnt  <= '0;
            srch_cnt <= '0;
            loss_cnt <= '0;
          end else if (srch_tmo) begin
            state    <= SLIP;
            bitslip  <= 1'b1;
            tok_cnt  <= '0;
            srch_cnt <= '0;
          end
        end

        SLIP: begin
          state    <= WAIT;
          wait_cnt <= '0;
        end

        WAIT: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (wait_done) begin
            state    <= SEARCH;
            wait_cnt <= '0;
            tok_cnt  <= '0;
            srch_cnt <= '0;
          end
        end

        LOCKED: begin
          if (loss_tmo) begin
            state    <= SEARCH;
            aligned  <= 1'b0;
            de       <= 1'b0;
            ctrl     <= 2'b00;
            data     <= 8'h00;
            loss_cnt <= '0;
            tok_cnt  <= '0;
            srch_cnt <= '0;
          end else if (is_tok) begin
            loss_cnt <= '0;
            de       <= 1'b0;
            ctrl     <= tok_ctrl;
            data     <= 8'h00;
          end else begin
            loss_cnt <= loss_cnt + 1'b1;
            de       <= 1'b1;
            data     <= dec;
          end
        end

        default: begin
          state <= SEARCH;
        end
      endcase
    end
  end

`ifdef TMDS_DEC_ERR_CNT_EN
  logic err_evt;

  // bitslip is high for exactly the SLIP cycle, so it marks each pulse once.
  assign err_evt = bitslip || ((state == LOCKED) && loss_tmo);

  always_ff @(posedge pixel_clock) begin
    if (reset)                                 err_count <= 16'h0000;
    else if (err_evt && err_count != 16'hFFFF) err_count <= err_count + 16'h0001;
  end
`else
  assign err_count = 16'h0000;
`endif

endmodule

// File: tb/tb_tmds_channel_decoder.sv
module tb_tmds_channel_decoder;

  localparam int CTM = 8;
  localparam int ST  = 64;
  localparam int BW  = 16;
  localparam int LT  = 64;

  localparam logic [9:0] TOK0 = 10'b1101010100;
  localparam logic [9:0] TOK1 = 10'b0010101011;
  localparam logic [9:0] TOK2 = 10'b0101010100;
  localparam logic [9:0] TOK3 = 10'b1010101011;

`ifdef TMDS_DEC_ERR_CNT_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic        pixel_clock = 1'b0;
  logic        reset;
  logic [9:0]  tmds_word;
  logic        bitslip;
  logic        aligned;
  logic        de;
  logic [1:0]  ctrl;
  logic [7:0]  data;
  logic [15:0] err_count;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Slip monitor state (written only by the monitor process)
  int   slip_cnt = 0;
  int   slip_cyc [8];
  int   offset   = 0;
  int   consec   = 0;
  logic prev_bs  = 1'b0;
  int   offset_load = 0;

  tmds_channel_decoder #(
    .CTRL_TOKEN_MIN (CTM),
    .SEARCH_TIMEOUT (ST),
    .BITSLIP_WAIT   (BW),
    .LINE_TIMEOUT   (LT)
  ) dut (
    .pixel_clock (pixel_clock),
    .reset       (reset),
    .tmds_word   (tmds_word),
    .bitslip     (bitslip),
    .aligned     (aligned),
    .de          (de),
    .ctrl        (ctrl),
    .data        (data),
    .err_count   (err_count)
  );

  always #5 pixel_clock = ~pixel_clock;

  always @(posedge pixel_clock) cyc++;

  // Models the deserializer: each bitslip pulse moves the boundary one bit
  // closer to the true alignment.
  always @(negedge pixel_clock) begin
    if (reset) begin
      offset   = offset_load;
      slip_cnt = 0;
      prev_bs  = 1'b0;
    end else begin
      if (bitslip) begin
        if (slip_cnt < 8) slip_cyc[slip_cnt] = cyc;
        slip_cnt++;
        if (offset > 0) offset--;
        if (prev_bs) consec++;
      end
      prev_bs = bitslip;
    end
  end

  task automatic tick();
    @(posedge pixel_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_token(input logic [9:0] w);
    return (w == TOK0) || (w == TOK1) || (w == TOK2) || (w == TOK3);
  endfunction

  function automatic logic [9:0] rotl(input logic [9:0] w, input int n);
    logic [19:0] t;
    t = {w, w} << n;
    return t[19:10];
  endfunction

  logic [9:0] vec_word [6];
  logic [7:0] vec_data [6];

  initial begin
    int nz;
    int guard;
    logic [9:0] rw;

    vec_word[0] = 10'h100; vec_data[0] = 8'h00;
    vec_word[1] = 10'h2FF; vec_data[1] = 8'hFE;
    vec_word[2] = 10'h001; vec_data[2] = 8'hFD;
    vec_word[3] = 10'h103; vec_data[3] = 8'h05;
    vec_word[4] = 10'h3FC; vec_data[4] = 8'h05;
    vec_word[5] = 10'h0B5; vec_data[5] = 8'h21;

    // Reset with random input
    reset = 1'b1;
    offset_load = 0;
    tmds_word = 10'h000;
    repeat (3) begin
      tmds_word = 10'($urandom);
      tick();
    end
    chk("rst_bitslip", bitslip, 0);
    chk("rst_aligned", aligned, 0);
    chk("rst_de", de, 0);
    chk("rst_ctrl", ctrl, 0);
    chk("rst_data", data, 0);
    chk("rst_err_count", err_count, 0);

    reset = 1'b0;
    nz = 0;
    repeat (ST - 1) begin
      rw = 10'($urandom);
      if (is_token(rw)) rw = 10'h000;
      tmds_word = rw;
      tick();
      if (bitslip || aligned || de || ctrl != 2'b00 || data != 8'h00 || err_count != 16'h0) nz++;
    end
    chk("no_slip_before_timeout", slip_cnt, 0);
    chk("idle_outputs_zero", nz, 0);
    tmds_word = 10'h000;
    tick();
    chk("first_slip_at_timeout", bitslip, 1);

    // Lock on control token 00
    reset = 1'b1;
    tmds_word = 10'h000;
    tick();
    tick();
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tmds_word = TOK0;
      tick();
      if (k == CTM) chk("aligned_not_before_8th", aligned, 0);
      if (k == CTM + 1) begin
        chk("aligned_after_8th", aligned, 1);
        chk("lock_ctrl", ctrl, 0);
        chk("lock_de", de, 0);
      end
    end

    // Data decode vectors, 2-cycle latency
    for (int v = 0; v < 6; v++) begin
      tmds_word = vec_word[v];
      tick();
      if (v == 0) chk("de_not_early", de, 0);
      tick();
      chk($sformatf("dec_de_%0d", v), de, 1);
      chk($sformatf("dec_data_%0d", v), data, vec_data[v]);
      chk($sformatf("dec_ctrl_%0d", v), ctrl, 0);
    end

    // Control token updates during lock
    tmds_word = TOK3;
    tick(); tick();
    chk("tok3_ctrl", ctrl, 2'b11);
    chk("tok3_de", de, 0);
    chk("tok3_data", data, 0);
    tmds_word = 10'h100;
    tick(); tick();
    chk("tok3_ctrl_held", ctrl, 2'b11);
    chk("tok3_then_de", de, 1);
    tmds_word = TOK1;
    tick(); tick();
    chk("tok1_ctrl", ctrl, 2'b01);
    tmds_word = TOK2;
    tick(); tick();
    chk("tok2_ctrl", ctrl, 2'b10);
    chk("tok2_de", de, 0);

    // Line timeout: LT data words drop lock, then a bitslip after ST
    tmds_word = 10'h100;
    repeat (LT) tick();
    chk("aligned_before_line_tmo", aligned, 1);
    tick();
    chk("loss_aligned", aligned, 0);
    chk("loss_de", de, 0);
    chk("loss_ctrl", ctrl, 0);
    chk("loss_data", data, 0);
    repeat (ST - 1) tick();
    chk("no_slip_before_search_tmo", bitslip, 0);
    tick();
    chk("slip_after_loss", bitslip, 1);
    tick();
    chk("slip_single_cycle", bitslip, 0);
    chk("err_after_loss_slip", err_count, ERR_EN ? 2 : 0);

    // Stream offset by 3 bits; needs three slips
    reset = 1'b1;
    offset_load = 3;
    tmds_word = 10'h000;
    tick();
    tick();
    reset = 1'b0;
    guard = 0;
    while (!aligned && guard < 600) begin
      tmds_word = rotl(TOK0, offset);
      tick();
      guard++;
    end
    chk("offset_lock", aligned, 1);
    chk("offset_slip_count", slip_cnt, 3);
    chk("offset_final", offset, 0);
    chk("slip_spacing_1", (slip_cyc[1] - slip_cyc[0]) >= (BW + ST + 1), 1);
    chk("slip_spacing_2", (slip_cyc[2] - slip_cyc[1]) >= (BW + ST + 1), 1);

    tmds_word = 10'h100;
    repeat (LT + 1) tick();
    chk("offset_loss_aligned", aligned, 0);
    chk("err_count_total", err_count, ERR_EN ? 4 : 0);
    chk("no_back_to_back_slip", consec, 0);

    // Reset while bitslip is asserted
    guard = 0;
    while (!bitslip && guard < 200) begin
      tick();
      guard++;
    end
    chk("slip_seen_before_reset", bitslip, 1);
    reset = 1'b1;
    tick();
    chk("mid_rst_bitslip", bitslip, 0);
    chk("mid_rst_aligned", aligned, 0);
    chk("mid_rst_err", err_count, 0);
    chk("mid_rst_de", de, 0);
    reset = 1'b0;
    tick();
    chk("slip_dropped", bitslip, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
